if_stage: RTL and testbench

//  Instruction-fetch stage. AXI4-Lite read master on instruction memory.

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// AXI4-Lite read-channel bundle between the fetch stage and instruction memory.
//   master: drives AR address/valid/prot and R ready (the fetch stage)
//   slave : drives AR ready and R data/response/valid (the memory)
interface if_stage_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. AXI4-Lite read master on instruction memory with one read
// outstanding at a time; fetched words go to decode through a valid/ready output register.
// Control-flow redirects from EX retarget the fetch PC and drop any stale in-flight response.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   imem_axi            AXI4-Lite read master (AR + R channels)
//   valid_out/ready_in  decode handshake; transfer when both high
//   jump_taken/addr     single-cycle redirect; target bits [1:0] forced to 00
//   PC_IF/IR_IF         address and word of the presented instruction
//   imem_axi_rresp_IF   AXI read response of the presented instruction
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  if_stage_if.master  imem_axi,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        jump_taken,
  input  logic [31:0] jump_addr,
  output logic [31:0] PC_IF,
  output logic [31:0] IR_IF,
  output logic [1:0]  imem_axi_rresp_IF
);

  typedef enum logic [0:0] {StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] jump_target;
  logic        rready;
  logic        ar_hs;
  logic        r_hs;

  assign jump_target = {jump_addr[31:2], 2'b00};
  // A dropped beat never needs the output register, so it is always accepted.
  assign rready      = (state_q == StResp) && (discard_q || !valid_q || ready_in);
  assign ar_hs       = arvalid_q && imem_axi.arready;
  assign r_hs        = (state_q == StResp) && imem_axi.rvalid && rready;

  always_comb begin
    state_d    = state_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rresp_d    = rresp_q;

    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StReq: begin
        if (!arvalid_q) begin
          // Only reachable right after reset: issue directly, a redirect needs no discard.
          arvalid_d = 1'b1;
          araddr_d  = jump_taken ? jump_target : fetch_pc_q;
        end else if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (r_hs) begin
          // Next request goes out immediately so the best case is one word per two cycles.
          state_d   = StReq;
          discard_d = 1'b0;
          arvalid_d = 1'b1;
          if (jump_taken) begin
            araddr_d = jump_target;
          end else if (discard_q) begin
            araddr_d = fetch_pc_q;
          end else begin
            pc_d       = fetch_pc_q;
            ir_d       = imem_axi.rdata;
            rresp_d    = imem_axi.rresp;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            araddr_d   = fetch_pc_q + 32'd4;
          end
        end
      end
      default: state_d = StReq;
    endcase

    // Redirect overrides everything above; an AR held by AXI rules keeps its old address.
    if (jump_taken) begin
      fetch_pc_d = jump_target;
      valid_d    = 1'b0;
      if (arvalid_q || (state_q == StResp && !r_hs)) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StReq;
      arvalid_q  <= 1'b0;
      araddr_q   <= 32'd0;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      ir_q       <= 32'd0;
      rresp_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rresp_q    <= rresp_d;
    end
  end

  assign imem_axi.araddr  = araddr_q;
  assign imem_axi.arprot  = 3'b100;
  assign imem_axi.arvalid = arvalid_q;
  assign imem_axi.rready  = rready;

  assign valid_out         = valid_q;
  assign PC_IF             = pc_q;
  assign IR_IF             = ir_q;
  assign imem_axi_rresp_IF = rresp_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        valid_out;
  logic        ready_in;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic [31:0] PC_IF;
  logic [31:0] IR_IF;
  logic [1:0]  rresp_IF;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .imem_axi          (bus),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .jump_taken        (jump_taken),
    .jump_addr         (jump_addr),
    .PC_IF             (PC_IF),
    .IR_IF             (IR_IF),
    .imem_axi_rresp_IF (rresp_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int accepts;
  int err_accepts;

  // Memory behaviour knobs: ar_mode 0=always ready, 1=random, 2=never; r_mode 0=next cycle,
  // 1=random 0..3 extra cycles, 2=3 extra cycles.
  int unsigned ar_mode;
  int unsigned r_mode;
  logic [31:0] ar_log[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a[6:2] == 5'd13) ? 2'b10 : 2'b00;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Program-order model: after a (re)start at pc the decode stage must see pc, pc+4, ...
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 60; n++) begin
      if (valid_out) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL %s: valid_out still 0 after 60 cycles, expected 1", name);
  endtask

  task automatic wait_log(input string name, input int n);
    for (int k = 0; k < 60; k++) begin
      if (ar_log.size() >= n) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL %s: %0d AR handshakes after 60 cycles, expected %0d", name, ar_log.size(), n);
  endtask

  // Instruction memory: one response per accepted read, rvalid held until rready.
  initial begin
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] ar_a;
    logic        pend;
    logic [31:0] pend_addr;
    int unsigned delay;
    pend = 1'b0;
    pend_addr = 32'd0;
    delay = 0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'd0;
    forever begin
      @(negedge clk);
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      ar_a  = bus.araddr;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pend = 1'b0;
        bus.rvalid  = 1'b0;
        bus.arready = 1'b0;
      end else begin
        if (r_hs) begin
          pend = 1'b0;
          bus.rvalid = 1'b0;
        end
        if (ar_hs) begin
          check1("one_outstanding", pend, 1'b0);
          pend      = 1'b1;
          pend_addr = ar_a;
          ar_log.push_back(ar_a);
          delay = (r_mode == 0) ? 0 : (r_mode == 1) ? $urandom_range(0, 3) : 3;
        end
        if (pend && !bus.rvalid) begin
          if (delay == 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem_word(pend_addr);
            bus.rresp  = mem_resp(pend_addr);
          end else begin
            delay--;
          end
        end
        bus.arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom % 2) : 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on every decode transfer, plus hold/flush/AXI-stability checks.
  initial begin
    logic        prev_hold;
    logic        prev_arwait;
    logic        prev_jump;
    logic [31:0] h_pc;
    logic [31:0] h_ir;
    logic [1:0]  h_rr;
    logic [31:0] h_araddr;
    logic [31:0] e;
    prev_hold = 1'b0;
    prev_arwait = 1'b0;
    prev_jump = 1'b0;
    h_pc = 32'd0;
    h_ir = 32'd0;
    h_rr = 2'd0;
    h_araddr = 32'd0;
    sb_restart(RESET_PC);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb_restart(RESET_PC);
        prev_hold = 1'b0;
        prev_arwait = 1'b0;
        prev_jump = 1'b0;
        continue;
      end
      if (prev_jump) check1("flush_after_jump", valid_out, 1'b0);
      if (prev_hold) begin
        check1("hold_valid", valid_out, 1'b1);
        check32("hold_pc", PC_IF, h_pc);
        check32("hold_ir", IR_IF, h_ir);
        check32("hold_rresp", {30'd0, rresp_IF}, {30'd0, h_rr});
      end
      if (prev_arwait) begin
        check1("ar_hold_valid", bus.arvalid, 1'b1);
        check32("ar_hold_addr", bus.araddr, h_araddr);
      end
      if (valid_out && ready_in) begin
        e = exp_q.pop_front();
        exp_q.push_back(exp_q[$] + 32'd4);
        check32("pc_order", PC_IF, e);
        check32("ir_data", IR_IF, mem_word(e));
        check32("rresp_pass", {30'd0, rresp_IF}, {30'd0, mem_resp(e)});
        accepts++;
        if (mem_resp(e) == 2'b10) err_accepts++;
      end
      if (jump_taken) sb_restart({jump_addr[31:2], 2'b00});
      prev_jump   = jump_taken;
      prev_hold   = valid_out && !ready_in && !jump_taken;
      h_pc        = PC_IF;
      h_ir        = IR_IF;
      h_rr        = rresp_IF;
      prev_arwait = bus.arvalid && !bus.arready;
      h_araddr    = bus.araddr;
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] held;
    logic        found;
    checks = 0;
    errors = 0;
    accepts = 0;
    err_accepts = 0;
    reset_n = 1'b0;
    ready_in = 1'b0;
    jump_taken = 1'b0;
    jump_addr = 32'd0;
    ar_mode = 0;
    r_mode = 0;
    repeat (3) step();

    // Reset state
    check1("rst_valid", valid_out, 1'b0);
    check32("rst_pc", PC_IF, 32'd0);
    check32("rst_ir", IR_IF, 32'd0);
    check32("rst_rresp", {30'd0, rresp_IF}, 32'd0);
    check32("rst_araddr", bus.araddr, 32'd0);
    check1("rst_arvalid", bus.arvalid, 1'b0);
    check1("rst_rready", bus.rready, 1'b0);

    // 1: full-speed streaming from RESET_PC
    ready_in = 1'b1;
    ar_log.delete();
    reset_n = 1'b1;
    #1;
    check1("arvalid_before_edge", bus.arvalid, 1'b0);
    step();
    check1("arvalid_first_edge", bus.arvalid, 1'b1);
    check32("first_araddr", bus.araddr, RESET_PC);
    for (int i = 0; i < 12; i++) begin
      step();
      check1($sformatf("stream_valid_%0d", i), valid_out, 1'(i % 2 == 1));
    end
    if (ar_log.size() >= 3) begin
      check32("stream_ar0", ar_log[0], 32'h0);
      check32("stream_ar1", ar_log[1], 32'h4);
      check32("stream_ar2", ar_log[2], 32'h8);
    end else begin
      check32("stream_ar_count", 32'(ar_log.size()), 32'd3);
    end

    // 2: decode backpressure
    wait_valid("bp_wait");
    ready_in = 1'b0;
    held = PC_IF;
    repeat (5) step();
    check32("bp_pc_held", PC_IF, held);
    check1("bp_rvalid", bus.rvalid, 1'b1);
    check1("bp_rready_low", bus.rready, 1'b0);
    ready_in = 1'b1;
    repeat (6) step();

    // 3: redirect while AR is stalled
    ar_mode = 2;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      found = bus.arvalid && !bus.arready;
    end
    check1("j1_ar_stalled", found, 1'b1);
    held = bus.araddr;
    ar_log.delete();
    jump_addr = 32'h100;
    jump_taken = 1'b1;
    step();
    jump_taken = 1'b0;
    check1("j1_arvalid_held", bus.arvalid, 1'b1);
    check32("j1_araddr_held", bus.araddr, held);
    ar_mode = 0;
    wait_log("j1_log", 2);
    if (ar_log.size() >= 2) begin
      check32("j1_old_ar", ar_log[0], held);
      check32("j1_new_ar", ar_log[1], 32'h100);
    end
    wait_valid("j1_valid");
    check32("j1_pc", PC_IF, 32'h100);
    repeat (4) step();

    // 4: redirect in the same cycle as a read beat
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      found = bus.rvalid && bus.rready;
    end
    check1("j2_beat_seen", found, 1'b1);
    ar_log.delete();
    jump_addr = 32'h203;
    jump_taken = 1'b1;
    step();
    jump_taken = 1'b0;
    check1("j2_valid_low", valid_out, 1'b0);
    wait_log("j2_log", 1);
    if (ar_log.size() >= 1) check32("j2_ar", ar_log[0], 32'h200);
    wait_valid("j2_valid");
    check32("j2_pc", PC_IF, 32'h200);
    repeat (4) step();

    // 5: error response forwarded, fetch continues
    jump_addr = 32'h34;
    jump_taken = 1'b1;
    step();
    jump_taken = 1'b0;
    wait_valid("err_valid");
    check32("err_pc", PC_IF, 32'h34);
    check32("err_rresp", {30'd0, rresp_IF}, 32'd2);
    step();
    wait_valid("err_next_valid");
    check32("err_next_pc", PC_IF, 32'h38);
    check32("err_next_rresp", {30'd0, rresp_IF}, 32'd0);

    // 6: reset with a response pending, then PC wrap
    r_mode = 2;
    ready_in = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      found = bus.rvalid && valid_out;
    end
    check1("rst2_pending", found, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("rst2_valid", valid_out, 1'b0);
    check32("rst2_pc", PC_IF, 32'd0);
    check32("rst2_ir", IR_IF, 32'd0);
    check32("rst2_rresp", {30'd0, rresp_IF}, 32'd0);
    check32("rst2_araddr", bus.araddr, 32'd0);
    check1("rst2_arvalid", bus.arvalid, 1'b0);
    check1("rst2_rready", bus.rready, 1'b0);
    repeat (2) step();
    r_mode = 0;
    ready_in = 1'b1;
    ar_log.delete();
    reset_n = 1'b1;
    wait_log("rst2_log", 1);
    if (ar_log.size() >= 1) check32("rst2_first_ar", ar_log[0], RESET_PC);
    jump_addr = 32'hFFFF_FFFE;
    jump_taken = 1'b1;
    step();
    jump_taken = 1'b0;
    wait_valid("wrap_valid");
    check32("wrap_pc_top", PC_IF, 32'hFFFF_FFFC);
    step();
    wait_valid("wrap_next_valid");
    check32("wrap_pc_zero", PC_IF, 32'h0);

    // Randomised traffic against the program-order model
    ar_mode = 1;
    r_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      ready_in = 1'(($urandom % 4) != 0);
      jump_taken = 1'(($urandom % 20) == 0);
      jump_addr = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      step();
    end
    jump_taken = 1'b0;
    ready_in = 1'b1;
    ar_mode = 0;
    r_mode = 0;
    repeat (20) step();
    check1("progress", 1'(accepts > 300), 1'b1);
    check1("error_resp_seen", 1'(err_accepts > 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
